avalon_arbiter: RTL

AVALON_ARBITER -- requirements
Module: avalon_arbiter

---
 rtl/avalon_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/avalon_arbiter.sv
// rtl/avalon_arbiter.sv - two-master (instruction/data) Avalon-MM arbiter with stall timeout.
// Optional round-robin arbitration between simultaneous requests: define AVALON_ARB_ROUND_ROBIN_EN.
module avalon_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ABORT_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic [1:0]  grant,
  output logic        timeout_flag
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] BUS_I = 2'b01;
  localparam logic [1:0] BUS_D = 2'b10;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          i_req, d_req, own_req, abort, pick_d, d_rd;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign d_rd    = d_read & ~d_write;
  assign own_req = (state_q == BUS_I) ? i_req : ((state_q == BUS_D) ? d_req : 1'b0);

  // Abort fires in the stalled cycle that brings the count up to TIMEOUT_CYCLES.
  assign abort = (TIMEOUT_CYCLES != 0) && own_req && m_waitrequest &&
                 ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

`ifdef AVALON_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  assign pick_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if ((state_q == IDLE) && (state_d != IDLE)) last_d_d = (state_d == BUS_D);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_d_q <= 1'b0;
    else          last_d_q <= last_d_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q | abort;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_d)     state_d = BUS_D;
        else if (i_req) state_d = BUS_I;
      end
      default: begin
        if (!own_req || !m_waitrequest || abort) state_d = IDLE;
        else if (cnt_q != CNT_MAX)               cnt_d   = cnt_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  // A granted master that has dropped its request drives nothing onto the slave.
  always_comb begin
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = '0;
    m_byteenable  = '0;
    i_waitrequest = i_req;
    i_readdata    = '0;
    d_waitrequest = d_req;
    d_readdata    = '0;
    case (state_q)
      BUS_I: begin
        if (i_req) begin
          m_address    = i_address;
          m_read       = 1'b1;
          m_byteenable = 4'b1111;
        end
        i_waitrequest = abort ? 1'b0 : m_waitrequest;
        i_readdata    = abort ? ABORT_DATA : m_readdata;
      end
      BUS_D: begin
        if (d_req) begin
          m_address    = d_address;
          m_read       = d_rd;
          m_write      = d_write;
          m_writedata  = d_writedata;
          m_byteenable = d_byteenable;
        end
        d_waitrequest = abort ? 1'b0 : m_waitrequest;
        d_readdata    = (abort && d_rd) ? ABORT_DATA : m_readdata;
      end
      default: ;
    endcase
  end

  assign grant        = state_q;
  assign timeout_flag = flag_q;

endmodule
